energy_ram_writer: RTL and testbench
====================================

Name: energy_ram_writer

Overview:
- Producer side of the direction-score RAM that the argmax scanner reads.
- Consumes a stream of signed beamformed samples, one block of ACC_LEN samples per steering index.
- Squares and accumulates each block into an energy value, then writes it to the RAM at addresses START_ADDR..END_ADDR.
- Raises a held done flag once the last index is written, so the scan can be released.

Parameters:
- DATA_WIDTH, 32: RAM word width; written values are signed, non-negative.
- ADDR_WIDTH, 8: RAM address width.
- SAMPLE_WIDTH, 16: signed input sample width.
- ACC_LEN, 64: samples accumulated per address; power of two, >= 2.
- START_ADDR, 88: first address written.
- END_ADDR, 168: last address written; END_ADDR >= START_ADDR.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a fill pass.
- sampleValid  in  1  sample is presented.
- sample  in  SAMPLE_WIDTH  signed input sample.
- sampleReady  out  1  block accepts a sample this cycle.
- we  out  1  RAM write enable.
- writeAddr  out  ADDR_WIDTH  RAM write address.
- writeData  out  DATA_WIDTH  RAM write data.
- busy  out  1  a pass is in progress (ACCUM or WRITE).
- done  out  1  held high after a full pass completes.

Behaviour:
- One clock domain (clk); rst is asynchronous and active-high.
- While rst is high: state=IDLE, we=0, writeAddr=0, writeData=0, sampleReady=0, busy=0, done=0; accumulator and counter cleared.
- Reset mid-pass aborts immediately. Any partial block is discarded. No write occurs.
- State IDLE:
  - sampleReady=0.
  - start -> ACCUM; addr=START_ADDR, acc=0, cnt=0.
- State ACCUM:
  - sampleReady=1.
  - A handshake occurs when sampleValid && sampleReady. On a handshake, acc += sample*sample and cnt++.
  - Samples presented with sampleValid=0 are ignored; no timeout.
  - Product: signed multiply, 2*SAMPLE_WIDTH bits, always non-negative. -2^(SW-1) squared = 2^(2SW-2) must not overflow.
  - acc width: 2*SAMPLE_WIDTH + log2(ACC_LEN). It never wraps.
  - On the handshake with cnt==ACC_LEN-1 -> WRITE.
- State WRITE (exactly 1 cycle):
  - we=1, writeAddr=addr, writeData=conv(acc); sampleReady=0.
  - If addr==END_ADDR -> DONE. Otherwise addr++, acc=0, cnt=0 -> ACCUM.
- State DONE:
  - done=1, sampleReady=0.
  - start -> ACCUM as from IDLE; done drops in the same transition.
- we, writeAddr and writeData are registered. we is high only in WRITE.
- writeAddr and writeData hold their last values when we=0.
- Latency: we asserts the cycle after the final accepted sample of a block.
- done asserts the cycle after the END_ADDR write.
- With no sampleValid gaps, a full pass takes (END_ADDR-START_ADDR+1)*(ACC_LEN+1) cycles from start to done.
- start during ACCUM or WRITE is ignored.
- busy = (state==ACCUM || state==WRITE).
- Addresses outside START_ADDR..END_ADDR are never written.
- writeData MSB is always 0, so a signed max scan sees non-negative energies.

Optional Feature:
- Macro: ENERGY_RAM_WRITER_SAT_EN.
- Defined: conv(acc) = {0, acc} if acc <= 2^(DATA_WIDTH-1)-1, else 2^(DATA_WIDTH-1)-1 (saturate).
- Undefined: conv(acc) = {0, acc[DATA_WIDTH-2:0]}. Upper bits are dropped and the value wraps.
- If acc fits in DATA_WIDTH-1 bits, both forms are identical.

Test Plan:
- ACC_LEN=4, START=88, END=90; start; sample=3 each cycle, valid always -> writes (88,36), (89,36), (90,36), each one cycle after the 4th sample. done rises the cycle after the addr-90 write. Exactly 3 we pulses.
- Negative input: block of samples -5,-5,2,0 -> writeData=54 at addr 88.
- Backpressure: sampleValid toggled 1,0,0,1,... over 4 accepted samples of 1 -> writeData=4. Accumulator unchanged on invalid cycles; cnt advances only on handshakes.
- Saturation (DATA_WIDTH=16, SAMPLE_WIDTH=16, ACC_LEN=4): samples all -32768, so acc=2^32.
  - With ENERGY_RAM_WRITER_SAT_EN: writeData=32767.
  - Without: writeData=0.
- Reset mid-pass: assert rst after 2 samples of addr 89 -> we=0, sampleReady=0, busy=0 immediately (asynchronously).
  - Then start; samples of 1 -> first write is (88,4).
- Restart and ignore: start pulsed during ACCUM has no effect. start in DONE clears done next cycle and re-writes 88..90 with new data (samples of 2 -> 16).

Source files
------------

// File: rtl/energy_ram_writer.sv
// energy_ram_writer: squares and accumulates sample blocks, writes energies.
// Optional ENERGY_RAM_WRITER_SAT_EN saturates written energies instead of wrapping.
module energy_ram_writer #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int SAMPLE_WIDTH = 16,
  parameter int ACC_LEN      = 64,
  parameter int START_ADDR   = 88,
  parameter int END_ADDR     = 168
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           sampleValid,
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  output logic                           sampleReady,
  output logic                           we,
  output logic [ADDR_WIDTH-1:0]          writeAddr,
  output logic [DATA_WIDTH-1:0]          writeData,
  output logic                           busy,
  output logic                           done
);

  localparam int CNT_W  = $clog2(ACC_LEN);
  localparam int ACC_W  = 2*SAMPLE_WIDTH + CNT_W;
  localparam int SQ_W   = 2*SAMPLE_WIDTH;
  localparam int CONV_W = (ACC_W > DATA_WIDTH-1) ? ACC_W : DATA_WIDTH-1;

  typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        acc_sum;
  logic [CNT_W-1:0]        cnt;
  logic signed [SQ_W-1:0]  sx;
  logic signed [SQ_W-1:0]  sq;
  logic [CONV_W-1:0]       sum_ext;
  logic [DATA_WIDTH-1:0]   conv;
  logic                    hs;
  logic                    last;
  logic                    at_end;

  // A square of a two's-complement value is at most 2^(2SW-2), so the
  // 2SW-bit product reinterpreted as unsigned is always exact.
  assign sx      = {{SAMPLE_WIDTH{sample[SAMPLE_WIDTH-1]}}, sample};
  assign sq      = sx * sx;
  assign acc_sum = acc + ACC_W'($unsigned(sq));
  assign hs      = sampleValid && (state == ACCUM);
  assign last    = hs && (cnt == CNT_W'(ACC_LEN-1));
  assign at_end  = (addr == ADDR_WIDTH'(END_ADDR));
  assign sum_ext = CONV_W'(acc_sum);

`ifdef ENERGY_RAM_WRITER_SAT_EN
  localparam logic [CONV_W-1:0] SAT_MAX = CONV_W'({(DATA_WIDTH-1){1'b1}});
  // Clamp to the largest positive signed value so the scan never sees a wrap.
  always_comb begin
    conv = {1'b0, sum_ext[DATA_WIDTH-2:0]};
    if (sum_ext > SAT_MAX)
      conv = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
`else
  logic unused_hi;
  assign unused_hi = ^sum_ext;
  // Keep the low bits only; MSB forced to zero so the value stays non-negative.
  always_comb begin
    conv = {1'b0, sum_ext[DATA_WIDTH-2:0]};
  end
`endif

  assign sampleReady = (state == ACCUM);
  assign busy        = (state == ACCUM) || (state == WRITE);
  assign done        = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = ACCUM;
      ACCUM: if (last)  state_nxt = WRITE;
      WRITE: state_nxt = at_end ? DONE : ACCUM;
      DONE:  if (start) state_nxt = ACCUM;
    endcase
  end

  // Accumulator, counter, address and registered RAM write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      acc       <= '0;
      cnt       <= '0;
      we        <= 1'b0;
      writeAddr <= '0;
      writeData <= '0;
    end else begin
      we <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            addr <= ADDR_WIDTH'(START_ADDR);
            acc  <= '0;
            cnt  <= '0;
          end
        end
        ACCUM: begin
          if (hs) begin
            acc <= acc_sum;
            cnt <= cnt + CNT_W'(1);
          end
          if (last) begin
            we        <= 1'b1;
            writeAddr <= addr;
            writeData <= conv;
          end
        end
        WRITE: begin
          if (!at_end) begin
            addr <= addr + ADDR_WIDTH'(1);
            acc  <= '0;
            cnt  <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_energy_ram_writer.sv
// tb_energy_ram_writer: scoreboard bench for energy_ram_writer.
// Reference model follows ENERGY_RAM_WRITER_SAT_EN like the design.
module tb_energy_ram_writer;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int SW = 16;
  localparam int AL = 4;
  localparam int SA = 88;
  localparam int EA = 90;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 sampleValid;
  logic signed [SW-1:0] sample;
  logic                 sampleReady;
  logic                 we;
  logic [AW-1:0]        writeAddr;
  logic [DW-1:0]        writeData;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int fails  = 0;
  int nwrites = 0;
  int npushed = 0;
  int cyc = 0;
  int exp_addr[$];
  longint exp_data[$];

  energy_ram_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SAMPLE_WIDTH(SW),
    .ACC_LEN(AL), .START_ADDR(SA), .END_ADDR(EA)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .sampleValid(sampleValid), .sample(sample),
    .sampleReady(sampleReady), .we(we),
    .writeAddr(writeAddr), .writeData(writeData),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic longint conv(input longint acc);
    longint lim;
    lim = (longint'(1) << (DW-1)) - 1;
`ifdef ENERGY_RAM_WRITER_SAT_EN
    return (acc > lim) ? lim : acc;
`else
    return acc % (lim + 1);
`endif
  endfunction

  // Monitor: every RAM write must match the oldest expected entry.
  always @(negedge clk) begin
    if (we) begin
      nwrites++;
      if (exp_addr.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write: addr %0d data %0d, none expected",
                 writeAddr, writeData);
      end else begin
        chk("write_addr", longint'(writeAddr), longint'(exp_addr.pop_front()));
        chk("write_data", longint'(writeData), exp_data.pop_front());
      end
    end
  end

  function automatic int pick(input int kind, input int cval, input int a, input int i);
    logic signed [SW-1:0] r;
    case (kind)
      1: return $urandom_range(0, 200) - 100;
      2: begin r = SW'($urandom); return int'(r); end
      3: return -32768;
      4: begin
        if (a != 0) return 1;
        case (i)
          0, 1: return -5;
          2: return 2;
          default: return 0;
        endcase
      end
      default: return cval;
    endcase
  endfunction

  task automatic send(input int s, input int gapm, input bit poke, input int idx);
    int gaps;
    int waited;
    gaps = (gapm == 0) ? 0 : (gapm == 1) ? $urandom_range(0, 2) : (idx == 0 ? 0 : 2);
    repeat (gaps) begin
      sampleValid = 1'b0;
      sample = SW'($urandom);
      start = poke ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
    end
    sample = SW'(s);
    sampleValid = 1'b1;
    start = poke ? 1'($urandom) : 1'b0;
    waited = 0;
    while (!sampleReady && waited < 20) begin
      @(posedge clk); #1;
      start = poke ? 1'($urandom) : 1'b0;
      waited++;
    end
    if (waited >= 20) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout: sampleReady 0 after %0d cycles, need 1", waited);
    end
    @(posedge clk); #1;
    sampleValid = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_pass(input int kind, input int cval, input int gapm,
                          input bit poke, input bit timed);
    int c0;
    int smp[AL];
    longint acc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c0 = cyc;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
    for (int a = 0; a <= EA - SA; a++) begin
      acc = 0;
      for (int i = 0; i < AL; i++) begin
        smp[i] = pick(kind, cval, a, i);
        acc += longint'(smp[i]) * longint'(smp[i]);
      end
      exp_addr.push_back(SA + a);
      exp_data.push_back(conv(acc));
      npushed++;
      for (int i = 0; i < AL; i++) send(smp[i], gapm, poke, i);
    end
    chk("done_in_write", done, 0);
    start = poke;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_after_last", done, 1);
    chk("busy_in_done", busy, 0);
    chk("ready_in_done", sampleReady, 0);
    if (timed) chk("pass_cycles", cyc - c0, (EA - SA + 1) * (AL + 1));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sampleValid = 1'b0;
    sample = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", we, 0);
    chk("rst_addr", writeAddr, 0);
    chk("rst_data", writeData, 0);
    chk("rst_ready", sampleReady, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    sampleValid = 1'b1;
    sample = 16'sd7;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_ready", sampleReady, 0);
      chk("idle_busy", busy, 0);
    end
    sampleValid = 1'b0;

    run_pass(0, 3, 0, 1'b0, 1'b1);
    run_pass(4, 0, 0, 1'b0, 1'b0);
    run_pass(0, 1, 2, 1'b0, 1'b0);
    run_pass(3, 0, 0, 1'b0, 1'b0);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr.push_back(SA);
    exp_data.push_back(conv(longint'(AL) * 9));
    npushed++;
    for (int i = 0; i < AL; i++) send(3, 0, 1'b0, i);
    for (int i = 0; i < 2; i++) send(1, 0, 1'b0, i);
    #2 rst = 1'b1;
    #1;
    chk("abort_we", we, 0);
    chk("abort_ready", sampleReady, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_addr", writeAddr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_pass(0, 1, 0, 1'b0, 1'b0);

    run_pass(0, 2, 1, 1'b1, 1'b0);

    for (int p = 0; p < 6; p++)
      run_pass($urandom_range(1, 2), 0, $urandom_range(0, 2), 1'($urandom), 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", exp_addr.size(), 0);
    chk("write_count", nwrites, npushed);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
